alu_muldiv: RTL and testbench

- Parametrised multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the EX stage.
- Executes MULT, MULTU, DIV, DIVU iteratively and holds results in architectural HI/LO registers; MTHI/MTLO write them directly.
- Control stalls the pipeline while busy=1 and reads hi/lo for MFHI/MFLO.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_muldiv_if.sv | 18 +
 rtl/alu_divstep.sv | 19 +
 rtl/alu_muldiv.sv | 157 +++++++++++++++
 tb/tb_alu_muldiv.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the multiply/divide unit and the EX-stage control that drives it.
package alu_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_MULT  = 3'b000;
  localparam op_t OP_MULTU = 3'b001;
  localparam op_t OP_DIV   = 3'b010;
  localparam op_t OP_DIVU  = 3'b011;
  localparam op_t OP_MTHI  = 3'b100;
  localparam op_t OP_MTLO  = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  function automatic logic is_signed_op(input op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/result bundle between EX-stage control and the multiply/divide unit.
interface alu_muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush,
                  input  busy, done, div_by_zero, hi, lo);
  modport slave  (input  start, op, a, b, flush,
                  output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/alu_divstep.sv
// One restoring-divide step: shift in the next dividend bit and subtract if it fits.
module alu_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, dvsr_i};
  // rem_i < dvsr_i bounds diff below 2^WIDTH, so the top bit is a clean borrow.
  assign q_o     = ~diff[WIDTH];
  assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO; one bit per cycle.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_muldiv_if.slave    bus
);
  localparam int CW = $clog2(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   div_rem;
  logic               div_q;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_s, rem_s;

  assign a_neg = is_signed_op(bus.op) & bus.a[WIDTH-1];
  assign b_neg = is_signed_op(bus.op) & bus.b[WIDTH-1];
  assign a_mag = a_neg ? -bus.a : bus.a;
  assign b_mag = b_neg ? -bus.b : bus.b;

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);

  alu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_i  (acc_q[2*WIDTH-1:WIDTH]),
    .bit_i  (acc_q[WIDTH-1]),
    .dvsr_i (opb_q),
    .rem_o  (div_rem),
    .q_o    (div_q)
  );

  assign prod  = neg_q_q ? -acc_q : acc_q;
  assign quo_s = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_s = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          dz_d = 1'b0;
          case (bus.op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              if (bus.op[1] && (bus.b == '0)) begin
                lo_d   = '1;
                hi_d   = bus.a;
                dz_d   = 1'b1;
                done_d = 1'b1;
              end else begin
                state_d  = ST_RUN;
                cnt_d    = '0;
                is_div_d = bus.op[1];
                acc_d    = {{WIDTH{1'b0}}, a_mag};
                opb_d    = b_mag;
                neg_q_d  = a_neg ^ b_neg;
                neg_r_d  = a_neg;
              end
            end
            OP_MTHI: begin
              hi_d   = bus.a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = bus.a;
              done_d = 1'b1;
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      ST_RUN: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = is_div_q ? {div_rem, acc_q[WIDTH-2:0], div_q}
                           : {mul_sum, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!bus.flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            lo_d = quo_s;
            hi_d = rem_s;
          end else begin
            lo_d = prod[WIDTH-1:0];
            hi_d = prod[2*WIDTH-1:WIDTH];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed table, random ops against an arithmetic reference, and flush/ignore/reset sequences.
module tb_alu_muldiv;
  import alu_pkg::*;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_muldiv_if #(.WIDTH(W)) bus ();
  alu_muldiv #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t         tbl[9];
  int           checks = 0, errors = 0;
  logic [W-1:0] m_hi, m_lo;
  logic         m_dz;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m_dz = 1'b0;
    case (op)
      OP_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      OP_DIV, OP_DIVU: begin
        if (b == 0) begin
          m_lo = '1; m_hi = a; m_dz = 1'b1;
        end else if (op == OP_DIV) begin
          p = sa / sb; m_lo = p[31:0];
          p = sa % sb; m_hi = p[31:0];
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  // lat = edges after acceptance up to the edge that raises done (0 for short ops).
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bcyc, output bit one_pulse);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0; bcyc = 0;
    while (lat < 200) begin
      @(negedge clk);
      if (bus.busy) bcyc++;
      if (bus.done) break;
      @(posedge clk);
      lat++;
    end
    @(negedge clk);
    one_pulse = !bus.done;
  endtask

  initial begin
    int lat, bcyc, n;
    bit one, saw;
    logic [2:0] op;
    logic [W-1:0] a, b;

    tbl[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    tbl[1] = '{OP_MULT,  32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    tbl[2] = '{OP_DIVU,  32'h7,        32'h2,        32'h1,        32'h3,        1'b0, 33};
    tbl[3] = '{OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    tbl[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 33};
    tbl[5] = '{OP_DIV,   32'h1234,     32'h0,        32'h1234,     32'hFFFFFFFF, 1'b1, 0};
    tbl[6] = '{OP_MTLO,  32'h5,        32'h0,        32'h1234,     32'h5,        1'b0, 0};
    tbl[7] = '{3'b110,   32'h99,       32'h3,        32'h1234,     32'h5,        1'b0, 0};
    tbl[8] = '{OP_MTHI,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h5,        1'b0, 0};

    bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dz",   bus.div_by_zero, 0);
    chk("rst_hi",   bus.hi, 0);
    chk("rst_lo",   bus.lo, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, bcyc, one);
      $display("vec %0d op=%0d a=%0h b=%0h", i, tbl[i].op, tbl[i].a, tbl[i].b);
      chk("tbl_hi",   bus.hi, tbl[i].hi);
      chk("tbl_lo",   bus.lo, tbl[i].lo);
      chk("tbl_dz",   bus.div_by_zero, tbl[i].dz);
      chk("tbl_lat",  lat, tbl[i].lat);
      chk("tbl_busy", bcyc, (tbl[i].lat == 0) ? 0 : W + 1);
      chk("tbl_pulse", one, 1);
    end
    m_hi = tbl[8].hi; m_lo = tbl[8].lo;

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0: b = '0;
        1: b = 32'($urandom_range(1, 20));
        2: b = '1;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      model(op, a, b);
      run_op(op, a, b, lat, bcyc, one);
      chk("rnd_hi", bus.hi, m_hi);
      chk("rnd_lo", bus.lo, m_lo);
      chk("rnd_dz", bus.div_by_zero, m_dz);
      chk("rnd_lat", lat, (op <= OP_DIVU && !(op[1] && b == 0)) ? W + 1 : 0);
    end

    // start during RUN must not disturb the in-flight divide
    @(negedge clk); bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 100; bus.b = 7;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); bus.start = 1'b1; bus.op = OP_MULT; bus.a = 3; bus.b = 3;
    @(posedge clk); #1 bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 100) begin @(negedge clk); n++; end
    chk("ign_done", bus.done, 1);
    chk("ign_lo", bus.lo, 14);
    chk("ign_hi", bus.hi, 2);
    @(negedge clk);
    chk("ign_idle", bus.busy, 0);

    // flush at step 10 drops the multiply with no done and no register change
    @(negedge clk); bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'h11; bus.b = 32'h22;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    chk("fl_busy", bus.busy, 0);
    saw = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.done) saw = 1'b1; end
    chk("fl_nodone", saw, 0);
    chk("fl_hi", bus.hi, 2);
    chk("fl_lo", bus.lo, 14);

    // flush beats start while idle
    @(negedge clk); bus.start = 1'b1; bus.flush = 1'b1; bus.op = OP_MTHI; bus.a = 32'h77;
    @(posedge clk); #1 bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    chk("flst_done", bus.done, 0);
    chk("flst_hi", bus.hi, 2);

    // asynchronous reset mid-multiply
    @(negedge clk); bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'hFFFF; bus.b = 32'hFFFF;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", bus.busy, 0);
    chk("ar_hi", bus.hi, 0);
    chk("ar_lo", bus.lo, 0);
    chk("ar_done", bus.done, 0);
    @(negedge clk) rst_n = 1'b1;
    run_op(OP_MTHI, 32'hA5A5A5A5, 32'h0, lat, bcyc, one);
    chk("ar_mthi_hi", bus.hi, 32'hA5A5A5A5);
    chk("ar_mthi_lo", bus.lo, 0);
    chk("ar_mthi_lat", lat, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
